// File: rtl/mm_seq_pkg.sv
// ============================================================================
//  Module      : mm_seq_pkg
//  Description : Shared state encoding and default geometry for the
//                matrix-multiply stream sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_seq_pkg;

    localparam int C_WIDTH       = 16;
    localparam int C_CHUNK_SIZE  = 4;
    localparam int C_NUM_CORES   = 2;
    localparam int C_NUM_I_WORDS = 4;
    localparam int C_NUM_W_WORDS = 6;
    localparam int C_NUM_O_WORDS = 6;
    localparam int C_I_AW        = 2;
    localparam int C_W_AW        = 3;
    localparam int C_O_AW        = 3;

    localparam logic [7:0] C_BRAM_WE_ALL = 8'hff;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mm_out_skid.sv
// ============================================================================
//  Module      : mm_out_skid
//  Description : Two-entry valid/ready skid buffer with occupancy output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_out_skid #(
    parameter int DATA_W = 128
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign s_ready   = (r_count != 2'd2);
    assign m_valid   = (r_count != 2'd0);
    assign m_data    = r_mem[r_rptr];
    assign occupancy = r_count;
    assign w_push    = s_valid && s_ready;
    assign w_pop     = m_valid && m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= s_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mm_stream_sequencer.sv
// ============================================================================
//  Module      : mm_stream_sequencer
//  Description : Loads input/weight streams into core BRAMs, starts the core,
//                waits for done and drains results onto an AXI-Stream master.
//                Optional macro MM_SEQ_PERF_CNT_EN adds perf_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_stream_sequencer
    import mm_seq_pkg::*;
#(
    parameter int WIDTH       = C_WIDTH,
    parameter int CHUNK_SIZE  = C_CHUNK_SIZE,
    parameter int NUM_CORES   = C_NUM_CORES,
    parameter int NUM_I_WORDS = C_NUM_I_WORDS,
    parameter int NUM_W_WORDS = C_NUM_W_WORDS,
    parameter int NUM_O_WORDS = C_NUM_O_WORDS,
    parameter int I_AW        = C_I_AW,
    parameter int W_AW        = C_W_AW,
    parameter int O_AW        = C_O_AW
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s_i_tvalid,
    output logic                                s_i_tready,
    input  logic                                s_i_tlast,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] s_i_tdata,
    input  logic                                s_w_tvalid,
    output logic                                s_w_tready,
    input  logic                                s_w_tlast,
    input  logic [WIDTH*CHUNK_SIZE-1:0]         s_w_tdata,
    output logic                                in_ena,
    output logic [7:0]                          in_wea,
    output logic [I_AW-1:0]                     in_addra,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_dina,
    output logic                                wb_ena,
    output logic [7:0]                          wb_wea,
    output logic [W_AW-1:0]                     wb_addra,
    output logic [WIDTH*CHUNK_SIZE-1:0]         wb_dina,
    output logic                                core_start,
    input  logic                                core_done,
    output logic                                out_enb,
    output logic [O_AW-1:0]                     out_addrb,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_doutb,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic                                m_tlast,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] m_tdata,
    output logic                                busy,
    output logic                                err_tlast
`ifdef MM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_cycles
`endif
);

    localparam int C_DW  = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int C_ICW = $clog2(NUM_I_WORDS + 1);
    localparam int C_WCW = $clog2(NUM_W_WORDS + 1);
    localparam int C_OCW = $clog2(NUM_O_WORDS + 1);

    localparam logic [C_ICW-1:0] C_I_FULL = C_ICW'(NUM_I_WORDS);
    localparam logic [C_ICW-1:0] C_I_LAST = C_ICW'(NUM_I_WORDS - 1);
    localparam logic [C_WCW-1:0] C_W_FULL = C_WCW'(NUM_W_WORDS);
    localparam logic [C_WCW-1:0] C_W_LAST = C_WCW'(NUM_W_WORDS - 1);
    localparam logic [C_OCW-1:0] C_O_FULL = C_OCW'(NUM_O_WORDS);
    localparam logic [C_OCW-1:0] C_O_LAST = C_OCW'(NUM_O_WORDS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [C_ICW-1:0]   r_i_cnt;
    logic [C_WCW-1:0]   r_w_cnt;
    logic [C_OCW-1:0]   r_rd_cnt;
    logic [C_OCW-1:0]   r_out_cnt;
    logic               r_inflight;
    logic               r_err_tlast;

    logic               w_i_hs;
    logic               w_w_hs;
    logic               w_i_last_bad;
    logic               w_w_last_bad;
    logic               w_rd_issue;
    logic               w_pop;
    logic               w_drain_done;
    logic               w_skid_ready;
    logic               w_skid_valid;
    logic [1:0]         w_occ;
    logic [2:0]         w_pending;

    assign w_i_hs       = s_i_tvalid && s_i_tready;
    assign w_w_hs       = s_w_tvalid && s_w_tready;
    assign w_i_last_bad = s_i_tlast != (r_i_cnt == C_I_LAST);
    assign w_w_last_bad = s_w_tlast != (r_w_cnt == C_W_LAST);
    assign w_pop        = w_skid_valid && m_tready;
    assign w_drain_done = w_pop && (r_out_cnt == C_O_LAST);

    // Words already buffered or on their way, minus the one leaving this cycle
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_next     = r_state;
        s_i_tready = 1'b0;
        s_w_tready = 1'b0;
        core_start = 1'b0;
        w_rd_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_i_tvalid || s_w_tvalid) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_i_tready = (r_i_cnt < C_I_FULL);
                s_w_tready = (r_w_cnt < C_W_FULL);
                if ((r_i_cnt == C_I_FULL) && (r_w_cnt == C_W_FULL)) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                core_start = 1'b1;
                w_next     = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (core_done) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_rd_issue = (r_rd_cnt < C_O_FULL) && (w_pending < 3'd2) && w_skid_ready;
                if (w_drain_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_i_cnt     <= '0;
            r_w_cnt     <= '0;
            r_rd_cnt    <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_err_tlast <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_issue;

            if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
                r_err_tlast <= 1'b0;
            end else if ((w_i_hs && w_i_last_bad) || (w_w_hs && w_w_last_bad)) begin
                r_err_tlast <= 1'b1;
            end

            if (w_i_hs) begin
                r_i_cnt <= r_i_cnt + C_ICW'(1);
            end
            if (w_w_hs) begin
                r_w_cnt <= r_w_cnt + C_WCW'(1);
            end
            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + C_OCW'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + C_OCW'(1);
            end

            if (w_drain_done) begin
                r_i_cnt   <= '0;
                r_w_cnt   <= '0;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end
        end
    end

    // BRAM write ports are combinational with the accepting handshake
    assign in_ena    = w_i_hs;
    assign in_wea    = w_i_hs ? C_BRAM_WE_ALL : 8'h00;
    assign in_addra  = w_i_hs ? I_AW'(r_i_cnt) : '0;
    assign in_dina   = w_i_hs ? s_i_tdata : '0;
    assign wb_ena    = w_w_hs;
    assign wb_wea    = w_w_hs ? C_BRAM_WE_ALL : 8'h00;
    assign wb_addra  = w_w_hs ? W_AW'(r_w_cnt) : '0;
    assign wb_dina   = w_w_hs ? s_w_tdata : '0;

    assign out_enb   = w_rd_issue;
    assign out_addrb = w_rd_issue ? O_AW'(r_rd_cnt) : '0;

    assign m_tvalid  = w_skid_valid;
    assign m_tlast   = w_skid_valid && (r_out_cnt == C_O_LAST);
    assign busy      = (r_state != ST_IDLE);
    assign err_tlast = r_err_tlast;

    mm_out_skid #(
        .DATA_W    (C_DW)
    ) u_out_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_valid   (r_inflight),
        .s_ready   (w_skid_ready),
        .s_data    (out_doutb),
        .m_valid   (w_skid_valid),
        .m_ready   (m_tready),
        .m_data    (m_tdata),
        .occupancy (w_occ)
    );

`ifdef MM_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_perf_cycles <= '0;
        end else if (r_state == ST_START) begin
            r_perf_cycles <= '0;
        end else if ((r_state == ST_COMPUTE) && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mm_stream_sequencer.sv
// ============================================================================
//  Module      : tb_mm_stream_sequencer
//  Description : Self-checking bench for mm_stream_sequencer driven by a table
//                of job records plus an in-drain reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mm_stream_sequencer;

    localparam int NI = 4;
    localparam int NW = 6;
    localparam int NO = 6;
    localparam int NJ = 7;

    logic         aclk;
    logic         aresetn;
    logic         s_i_tvalid, s_i_tready, s_i_tlast;
    logic [127:0] s_i_tdata;
    logic         s_w_tvalid, s_w_tready, s_w_tlast;
    logic [63:0]  s_w_tdata;
    logic         in_ena;
    logic [7:0]   in_wea;
    logic [1:0]   in_addra;
    logic [127:0] in_dina;
    logic         wb_ena;
    logic [7:0]   wb_wea;
    logic [2:0]   wb_addra;
    logic [63:0]  wb_dina;
    logic         core_start, core_done;
    logic         out_enb;
    logic [2:0]   out_addrb;
    logic [127:0] out_doutb;
    logic         m_tvalid, m_tready, m_tlast;
    logic [127:0] m_tdata;
    logic         busy, err_tlast;
`ifdef MM_SEQ_PERF_CNT_EN
    logic [31:0]  perf_cycles;
`endif

    logic         any_out;
    logic [3:0]   job_k;
    int           n_tests;
    int           n_fail;
    bit           prev_err;

    typedef struct {
        logic [7:0] i_gap;
        bit         w_first;
        logic [7:0] rdy_pat;
        logic [3:0] i_flip;
        int         done_dly;
        int         abort_after;
        bit         exp_err;
        int         exp_last_cyc;
    } job_t;

    job_t jobs [NJ];

    mm_stream_sequencer dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_i_tvalid (s_i_tvalid),
        .s_i_tready (s_i_tready),
        .s_i_tlast  (s_i_tlast),
        .s_i_tdata  (s_i_tdata),
        .s_w_tvalid (s_w_tvalid),
        .s_w_tready (s_w_tready),
        .s_w_tlast  (s_w_tlast),
        .s_w_tdata  (s_w_tdata),
        .in_ena     (in_ena),
        .in_wea     (in_wea),
        .in_addra   (in_addra),
        .in_dina    (in_dina),
        .wb_ena     (wb_ena),
        .wb_wea     (wb_wea),
        .wb_addra   (wb_addra),
        .wb_dina    (wb_dina),
        .core_start (core_start),
        .core_done  (core_done),
        .out_enb    (out_enb),
        .out_addrb  (out_addrb),
        .out_doutb  (out_doutb),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .busy       (busy),
        .err_tlast  (err_tlast)
`ifdef MM_SEQ_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    assign any_out = |{s_i_tready, s_w_tready, in_ena, in_wea, in_addra, in_dina,
                       wb_ena, wb_wea, wb_addra, wb_dina, core_start, out_enb,
                       out_addrb, m_tvalid, m_tlast, m_tdata, busy, err_tlast};

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [127:0] in_word(input logic [3:0] k, input logic [3:0] i);
        return {16{k, i}};
    endfunction

    function automatic logic [63:0] wt_word(input logic [3:0] k, input logic [3:0] i);
        return {8{~k, i}};
    endfunction

    function automatic logic [127:0] out_word(input logic [3:0] k, input logic [3:0] a);
        return {8{k, 4'h9, 4'h3, a}};
    endfunction

    // Output BRAM: one-cycle registered read
    always @(posedge aclk) begin
        if (out_enb) out_doutb <= out_word(job_k, {1'b0, out_addrb});
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input int k, input job_t r);
        int  i_idx = 0, w_idx = 0, cyc = 0, beat = 0, rd_n = 0, last_cyc = -1;
        int  n_in_wr = 0, n_wb_wr = 0;
        bit  i_pend = 0, i_hs, w_hs, stalled = 0, got_start = 0;
        logic [127:0] prev_data = '0;

        job_k = 4'(k);
        // Load phase
        while ((i_idx < NI || w_idx < NW) && cyc < 200) begin
            @(negedge aclk);
            s_i_tvalid = (i_idx < NI) && (i_pend || (r.i_gap[cyc % 8] && (!r.w_first || w_idx == NW)));
            s_i_tdata  = in_word(4'(k), 4'(i_idx));
            s_i_tlast  = (i_idx < NI) ? ((i_idx == NI - 1) ^ r.i_flip[i_idx[1:0]]) : 1'b0;
            s_w_tvalid = (w_idx < NW);
            s_w_tdata  = wt_word(4'(k), 4'(w_idx));
            s_w_tlast  = (w_idx == NW - 1);
            #1;
            if (cyc == 0) begin
                chk("idle_ready_low", 128'({s_i_tready, s_w_tready}), 128'd0);
                chk("err_held_in_idle", 128'(err_tlast), 128'(prev_err));
            end
            if (cyc == 1) chk("err_clear_on_load", 128'(err_tlast), 128'd0);
            if (i_idx == NI) chk("i_tready_full", 128'(s_i_tready), 128'd0);
            if (w_idx == NW) chk("w_tready_full", 128'(s_w_tready), 128'd0);
            chk("no_early_start", 128'(core_start), 128'd0);
            i_hs = s_i_tvalid && s_i_tready;
            w_hs = s_w_tvalid && s_w_tready;
            chk("in_ena_on_hs", 128'(in_ena), 128'(i_hs));
            chk("wb_ena_on_hs", 128'(wb_ena), 128'(w_hs));
            if (in_ena) begin
                chk("in_wea", 128'(in_wea), 128'hff);
                chk("in_addra", 128'(in_addra), 128'(i_idx));
                chk("in_dina", in_dina, in_word(4'(k), 4'(i_idx)));
                n_in_wr++;
            end
            if (wb_ena) begin
                chk("wb_wea", 128'(wb_wea), 128'hff);
                chk("wb_addra", 128'(wb_addra), 128'(w_idx));
                chk("wb_dina", 128'(wb_dina), 128'(wt_word(4'(k), 4'(w_idx))));
                n_wb_wr++;
            end
            i_pend = s_i_tvalid && !i_hs;
            if (i_hs) i_idx++;
            if (w_hs) w_idx++;
            cyc++;
        end
        chk("load_complete", 128'({i_idx[7:0], w_idx[7:0]}), 128'({8'(NI), 8'(NW)}));
        chk("in_write_count", 128'(n_in_wr), 128'(NI));
        chk("wb_write_count", 128'(n_wb_wr), 128'(NW));

        @(negedge aclk);
        s_i_tvalid = 1'b0;
        s_w_tvalid = 1'b0;
        s_i_tlast  = 1'b0;
        s_w_tlast  = 1'b0;
        for (int c = 0; c < 8 && !got_start; c++) begin
            #1;
            if (core_start) got_start = 1;
            else @(negedge aclk);
        end
        chk("core_start_seen", 128'(got_start), 128'd1);
        chk("busy_in_start", 128'(busy), 128'd1);

        for (int c = 1; c <= r.done_dly; c++) begin
            @(negedge aclk);
            #1;
            chk("start_one_cycle", 128'(core_start), 128'd0);
            chk("busy_compute", 128'(busy), 128'd1);
            if (c == r.done_dly) core_done = 1'b1;
        end
        @(negedge aclk);
        core_done = 1'b0;

        // Drain phase; cyc 0 is the first DRAIN cycle
        cyc = 0;
        while (beat < NO && cyc < 100) begin
            m_tready = r.rdy_pat[cyc % 8];
            #1;
            if (cyc < 2) chk("tvalid_not_early", 128'(m_tvalid), 128'd0);
            if (out_enb) begin
                chk("rd_addr_order", 128'(out_addrb), 128'(rd_n));
                rd_n++;
            end
            if (stalled) begin
                chk("stall_valid_hold", 128'(m_tvalid), 128'd1);
                chk("stall_data_hold", m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                chk("m_tdata", m_tdata, out_word(4'(k), 4'(beat)));
                chk("m_tlast", 128'(m_tlast), 128'(beat == NO - 1));
                beat++;
                last_cyc = cyc;
            end
            stalled   = m_tvalid && !m_tready;
            prev_data = m_tdata;
            if (r.abort_after != 0 && beat == r.abort_after) begin
                #1;
                aresetn = 1'b0;
                #1;
                chk("abort_outputs_zero", 128'(any_out), 128'd0);
                m_tready = 1'b0;
                repeat (2) @(negedge aclk);
                aresetn = 1'b1;
                @(negedge aclk);
                #1;
                chk("abort_idle", 128'({busy, m_tvalid, err_tlast}), 128'd0);
                prev_err = 1'b0;
                return;
            end
            @(negedge aclk);
            cyc++;
        end
        chk("drain_complete", 128'(beat), 128'(NO));
        if (r.exp_last_cyc >= 0) chk("no_bubbles", 128'(last_cyc), 128'(r.exp_last_cyc));
        chk("read_count", 128'(rd_n), 128'(NO));
        chk("err_tlast_job", 128'(err_tlast), 128'(r.exp_err));

        m_tready = 1'b0;
        #1;
        chk("busy_drop", 128'(busy), 128'd0);
        chk("m_tvalid_drop", 128'(m_tvalid), 128'd0);
        chk("err_sticky_idle", 128'(err_tlast), 128'(r.exp_err));
`ifdef MM_SEQ_PERF_CNT_EN
        chk("perf_cycles", 128'(perf_cycles), 128'(r.done_dly));
`endif
        prev_err = r.exp_err;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        prev_err   = 1'b0;
        job_k      = 4'd0;
        aresetn    = 1'b0;
        s_i_tvalid = 1'b0;
        s_i_tlast  = 1'b0;
        s_i_tdata  = '0;
        s_w_tvalid = 1'b0;
        s_w_tlast  = 1'b0;
        s_w_tdata  = '0;
        core_done  = 1'b0;
        m_tready   = 1'b0;

        //           i_gap        wfirst rdy_pat  i_flip   done abort err last
        jobs[0] = '{8'hFF,        1'b0,  8'hFF,   4'b0000, 10,  0,    1'b0, 7};
        jobs[1] = '{8'b1011_0101, 1'b1,  8'hFF,   4'b0000, 3,   0,    1'b0, 7};
        jobs[2] = '{8'hFF,        1'b0,  8'h99,   4'b0000, 5,   0,    1'b0, -1};
        jobs[3] = '{8'hFF,        1'b0,  8'hFF,   4'b1010, 4,   0,    1'b1, 7};
        jobs[4] = '{8'b0110_1101, 1'b0,  8'hFF,   4'b0000, 2,   0,    1'b0, 7};
        jobs[5] = '{8'hFF,        1'b0,  8'hFF,   4'b0000, 6,   3,    1'b0, -1};
        jobs[6] = '{8'hFF,        1'b0,  8'hFF,   4'b0000, 25,  0,    1'b0, 7};

        repeat (2) @(negedge aclk);
        #1;
        chk("reset_outputs", 128'(any_out), 128'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        for (int j = 0; j < NJ; j++) begin
            run_job(j + 1, jobs[j]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
